// File: rtl/key_event_pkg.sv
// -----------------------------------------------------------------------------
// key_event_pkg
//   Shared constants for the front-panel key handling and the controller that
//   consumes its events: per-key FSM state encoding, default timing values,
//   key-to-function mapping and the mode / edit-position encodings.
//
//   Contents
//     NUM_KEYS          number of front-panel push-buttons
//     DEF_*             default timing parameters for key_event
//     key_state_t       per-key debounce / hold FSM state
//     mode_t, pos_t     controller mode and edit-position encodings
//     KEY_*             bit index of each key in the key_event buses
//     cnt_width()       width needed to hold a count 0..max_val
// -----------------------------------------------------------------------------
package key_event_pkg;

    localparam int NUM_KEYS = 4;

    // Defaults for a 50 MHz clk: 100 Hz sampling, 3-sample debounce,
    // 1 s long press, 200 ms auto-repeat.
    localparam int DEF_TICK_DIV   = 500000;
    localparam int DEF_DEB_CNT    = 3;
    localparam int DEF_LONG_TICKS = 100;
    localparam int DEF_RPT_TICKS  = 20;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEB_PRESS = 3'd1,
        ST_PRESSED   = 3'd2,
        ST_HELD      = 3'd3,
        ST_DEB_REL   = 3'd4
    } key_state_t;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        POS_HOUR = 2'd0,
        POS_MIN  = 2'd1,
        POS_SEC  = 2'd2
    } pos_t;

    // Key roles: o_press drives mode / position / alarm-enable,
    // o_evt drives increment (press plus auto-repeat).
    localparam int KEY_MODE  = 0;
    localparam int KEY_POS   = 1;
    localparam int KEY_INC   = 2;
    localparam int KEY_ALARM = 3;

    // ceil(log2(max_val+1)), never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_fsm.sv
// -----------------------------------------------------------------------------
// key_fsm
//   Debounce, long-press and auto-repeat state machine for one key. All
//   state changes happen on sample ticks; every output is registered, so a
//   pulse appears in the clk cycle after the tick that caused it and lasts
//   exactly one clk.
//
//   Ports
//     clk, rst_n  system clock, asynchronous active-low reset
//     tick        one-clk sample strobe shared by all keys
//     low         synchronized raw sample, 1 = key physically pressed
//     level       debounced state, 1 = pressed
//     press       one-clk pulse per accepted press
//     rel         one-clk pulse per accepted release
//     long_hit    one-clk pulse when a hold reaches P_LONG_TICKS
//     evt         one-clk pulse on press, on long press and on each repeat
// -----------------------------------------------------------------------------
module key_fsm
    import key_event_pkg::*;
#(
    parameter int P_DEB_CNT    = DEF_DEB_CNT,
    parameter int P_LONG_TICKS = DEF_LONG_TICKS,
    parameter int P_RPT_TICKS  = DEF_RPT_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic low,
    output logic level,
    output logic press,
    output logic rel,
    output logic long_hit,
    output logic evt
);

    localparam int SMP_W  = cnt_width(P_DEB_CNT);
    localparam int HOLD_W = cnt_width(P_LONG_TICKS);
    localparam int RPT_W  = cnt_width(P_RPT_TICKS);

    localparam logic [SMP_W-1:0]  SMP_MAX  = '1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
    localparam logic [RPT_W-1:0]  RPT_MAX  = '1;

    key_state_t        state;
    key_state_t        resume_state;   // PRESSED or HELD, restored on a release bounce
    key_state_t        held_state;
    logic [SMP_W-1:0]  smp_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [RPT_W-1:0]  rpt_cnt;

    logic [SMP_W-1:0]  smp_inc;
    logic [HOLD_W-1:0] hold_inc;
    logic [RPT_W-1:0]  rpt_inc;
    logic              deb_done;
    logic              long_done;
    logic              rpt_done;

    // Saturating increments: the counters stop at all-ones instead of wrapping.
    assign smp_inc  = (smp_cnt  == SMP_MAX)  ? smp_cnt  : smp_cnt  + SMP_W'(1);
    assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);
    assign rpt_inc  = (rpt_cnt  == RPT_MAX)  ? rpt_cnt  : rpt_cnt  + RPT_W'(1);

    // Thresholds are checked against the count this tick would produce.
    assign deb_done  = (32'(smp_inc)  >= 32'(P_DEB_CNT));
    assign long_done = (32'(hold_inc) >= 32'(P_LONG_TICKS));
    assign rpt_done  = (32'(rpt_inc)  >= 32'(P_RPT_TICKS));

    // A low sample seen while debouncing a release is handled exactly as a
    // held sample of the state the key came from, so only the high sample
    // itself is lost from the hold / repeat timing.
    assign held_state = (state == ST_DEB_REL) ? resume_state : state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            resume_state <= ST_PRESSED;
            smp_cnt      <= '0;
            hold_cnt     <= '0;
            rpt_cnt      <= '0;
            level        <= 1'b0;
            press        <= 1'b0;
            rel          <= 1'b0;
            long_hit     <= 1'b0;
            evt          <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; the
            // pulse outputs default low here so every pulse lasts one clk.
            press    <= 1'b0;
            rel      <= 1'b0;
            long_hit <= 1'b0;
            evt      <= 1'b0;

            if (tick) begin
                unique case (state)
                    ST_IDLE: begin
                        if (low) begin
                            if (P_DEB_CNT <= 1) begin
                                state    <= ST_PRESSED;
                                level    <= 1'b1;
                                press    <= 1'b1;
                                evt      <= 1'b1;
                                hold_cnt <= '0;
                                smp_cnt  <= '0;
                            end else begin
                                state   <= ST_DEB_PRESS;
                                smp_cnt <= SMP_W'(1);
                            end
                        end
                    end

                    ST_DEB_PRESS: begin
                        if (!low) begin
                            state   <= ST_IDLE;
                            smp_cnt <= '0;
                        end else if (deb_done) begin
                            state    <= ST_PRESSED;
                            level    <= 1'b1;
                            press    <= 1'b1;
                            evt      <= 1'b1;
                            hold_cnt <= '0;
                            smp_cnt  <= '0;
                        end else begin
                            smp_cnt <= smp_inc;
                        end
                    end

                    ST_PRESSED, ST_HELD, ST_DEB_REL: begin
                        if (low) begin
                            smp_cnt <= '0;
                            if (held_state == ST_PRESSED) begin
                                hold_cnt <= hold_inc;
                                if (long_done) begin
                                    state    <= ST_HELD;
                                    long_hit <= 1'b1;
                                    evt      <= 1'b1;
                                    rpt_cnt  <= '0;
                                end else begin
                                    state <= ST_PRESSED;
                                end
                            end else begin
                                state <= ST_HELD;
                                if (rpt_done) begin
                                    evt     <= 1'b1;
                                    rpt_cnt <= '0;
                                end else begin
                                    rpt_cnt <= rpt_inc;
                                end
                            end
                        end else if (state == ST_DEB_REL) begin
                            if (deb_done) begin
                                state   <= ST_IDLE;
                                level   <= 1'b0;
                                rel     <= 1'b1;
                                smp_cnt <= '0;
                            end else begin
                                smp_cnt <= smp_inc;
                            end
                        end else if (P_DEB_CNT <= 1) begin
                            state <= ST_IDLE;
                            level <= 1'b0;
                            rel   <= 1'b1;
                        end else begin
                            // Hold / repeat counters are left untouched while
                            // the release is being debounced.
                            state        <= ST_DEB_REL;
                            resume_state <= state;
                            smp_cnt      <= SMP_W'(1);
                        end
                    end

                    default: begin
                        state   <= ST_IDLE;
                        level   <= 1'b0;
                        smp_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/key_event.sv
// -----------------------------------------------------------------------------
// key_event
//   Front-panel key conditioning for the clock controller. Synchronizes the
//   four active-low push-buttons, divides clk down to a common sample tick
//   and runs one key_fsm per key to produce debounced levels and event
//   pulses. o_press[0]/[1]/[3] drive mode / position / alarm-enable and
//   o_evt[2] drives the setup / alarm increment.
//
//   Ports
//     clk        system clock (50 MHz)
//     rst_n      asynchronous active-low reset
//     i_sw       raw push-buttons, 0 = pressed, asynchronous to clk
//     o_level    debounced key state, 1 = pressed
//     o_press    one-clk pulse per accepted press
//     o_release  one-clk pulse per accepted release
//     o_long     one-clk pulse once per hold reaching P_LONG_TICKS
//     o_evt      one-clk pulse on press or auto-repeat
// -----------------------------------------------------------------------------
module key_event
    import key_event_pkg::*;
#(
    parameter int P_TICK_DIV   = DEF_TICK_DIV,
    parameter int P_DEB_CNT    = DEF_DEB_CNT,
    parameter int P_LONG_TICKS = DEF_LONG_TICKS,
    parameter int P_RPT_TICKS  = DEF_RPT_TICKS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] i_sw,
    output logic [NUM_KEYS-1:0] o_level,
    output logic [NUM_KEYS-1:0] o_press,
    output logic [NUM_KEYS-1:0] o_release,
    output logic [NUM_KEYS-1:0] o_long,
    output logic [NUM_KEYS-1:0] o_evt
);

    localparam int TICK_W = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(P_TICK_DIV - 1);

    logic [NUM_KEYS-1:0] sw_meta;
    logic [NUM_KEYS-1:0] sw_sync;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;

    // Two-flop synchronizer. Flops reset to 1 so every key reads as released
    // until real samples arrive; a key held through reset is then seen as a
    // fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '1;
            sw_sync <= '1;
        end else begin
            sw_meta <= i_sw;
            sw_sync <= sw_meta;
        end
    end

    // Shared sample tick: high for the single clk where the count is at its
    // last value, after which the count wraps to 0.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_fsm #(
            .P_DEB_CNT    (P_DEB_CNT),
            .P_LONG_TICKS (P_LONG_TICKS),
            .P_RPT_TICKS  (P_RPT_TICKS)
        ) u_key_fsm (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .low      (~sw_sync[k]),
            .level    (o_level[k]),
            .press    (o_press[k]),
            .rel      (o_release[k]),
            .long_hit (o_long[k]),
            .evt      (o_evt[k])
        );
    end

endmodule

// File: tb/tb_key_event.sv
// -----------------------------------------------------------------------------
// tb_key_event
//   Directed bench for key_event with a 4-clk tick, 3-sample debounce,
//   10-tick long press and 4-tick repeat. Inputs change just after a tick
//   edge and are sampled by the following tick; outputs are checked 1 ns
//   after the tick edge that registers them. A negedge monitor counts every
//   pulse and flags pulses longer than one clk or press/release overlap.
// -----------------------------------------------------------------------------
module tb_key_event;

    localparam int TICK_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] i_sw;
    logic [3:0] o_level;
    logic [3:0] o_press;
    logic [3:0] o_release;
    logic [3:0] o_long;
    logic [3:0] o_evt;

    int vectors;
    int miscompares;

    int press_cnt   [4];
    int release_cnt [4];
    int long_cnt    [4];
    int evt_cnt     [4];
    int pulse_viol;

    logic [3:0] prev_press, prev_release, prev_long, prev_evt;
    int         phase;

    key_event #(
        .P_TICK_DIV   (TICK_DIV),
        .P_DEB_CNT    (3),
        .P_LONG_TICKS (10),
        .P_RPT_TICKS  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_sw      (i_sw),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long),
        .o_evt     (o_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench's own view of the tick phase: 0 right after each tick edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= 0;
        else        phase <= (phase == TICK_DIV - 1) ? 0 : phase + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                press_cnt[k]   <= press_cnt[k]   + int'(o_press[k]);
                release_cnt[k] <= release_cnt[k] + int'(o_release[k]);
                long_cnt[k]    <= long_cnt[k]    + int'(o_long[k]);
                evt_cnt[k]     <= evt_cnt[k]     + int'(o_evt[k]);
            end
            if (((o_press & prev_press) | (o_release & prev_release) |
                 (o_long & prev_long) | (o_evt & prev_evt) |
                 (o_press & o_release)) != 4'b0)
                pulse_viol <= pulse_viol + 1;
        end
        prev_press   <= o_press;
        prev_release <= o_release;
        prev_long    <= o_long;
        prev_evt     <= o_evt;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to n tick edges later, then settle 1 ns.
    task automatic run_ticks(input int n);
        repeat (n) begin
            do begin
                @(posedge clk);
                #1;
            end while (phase != 0);
        end
    endtask

    task automatic one_clk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        pulse_viol   = 0;
        prev_press   = '0;
        prev_release = '0;
        prev_long    = '0;
        prev_evt     = '0;
        for (int k = 0; k < 4; k++) begin
            press_cnt[k]   = 0;
            release_cnt[k] = 0;
            long_cnt[k]    = 0;
            evt_cnt[k]     = 0;
        end

        i_sw  = 4'hF;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_level", 32'(o_level), 32'h0);
        check("reset_pulses", 32'({o_press, o_release, o_long, o_evt}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Key 0: five low ticks then release.
        i_sw = 4'b1110;
        run_ticks(2);
        check("k0_press_early", 32'(o_press), 32'h0);
        check("k0_level_early", 32'(o_level), 32'h0);
        run_ticks(1);
        check("k0_press", 32'(o_press), 32'h1);
        check("k0_evt", 32'(o_evt), 32'h1);
        check("k0_level", 32'(o_level), 32'h1);
        one_clk();
        check("k0_press_1clk", 32'(o_press), 32'h0);
        run_ticks(2);
        i_sw = 4'b1111;
        run_ticks(2);
        check("k0_release_early", 32'(o_release), 32'h0);
        check("k0_level_held", 32'(o_level), 32'h1);
        run_ticks(1);
        check("k0_release", 32'(o_release), 32'h1);
        check("k0_level_drop", 32'(o_level), 32'h0);
        one_clk();
        check("k0_release_1clk", 32'(o_release), 32'h0);
        check("k0_press_count", 32'(press_cnt[0]), 32'd1);
        check("k0_release_count", 32'(release_cnt[0]), 32'd1);

        // Key 1: bounce low-high-low-high, one tick each.
        i_sw = 4'b1101; run_ticks(1);
        i_sw = 4'b1111; run_ticks(1);
        i_sw = 4'b1101; run_ticks(1);
        i_sw = 4'b1111; run_ticks(4);
        check("k1_bounce_level", 32'(o_level), 32'h0);
        check("k1_bounce_press", 32'(press_cnt[1]), 32'd0);
        check("k1_bounce_evt", 32'(evt_cnt[1]), 32'd0);

        // Key 2: long hold with auto-repeat.
        i_sw = 4'b1011;
        run_ticks(3);
        check("k2_press", 32'(o_press), 32'h4);
        check("k2_press_evt", 32'(o_evt), 32'h4);
        run_ticks(9);
        check("k2_long_early", 32'(long_cnt[2]), 32'd0);
        check("k2_evt_before_long", 32'(evt_cnt[2]), 32'd1);
        run_ticks(1);
        check("k2_long", 32'(o_long), 32'h4);
        check("k2_long_evt", 32'(o_evt), 32'h4);
        for (int r = 0; r < 5; r++) begin
            run_ticks(3);
            check($sformatf("k2_rpt%0d_gap", r), 32'(o_evt), 32'h0);
            run_ticks(1);
            check($sformatf("k2_rpt%0d", r), 32'(o_evt), 32'h4);
        end
        one_clk();
        check("k2_evt_total", 32'(evt_cnt[2]), 32'd7);
        check("k2_long_total", 32'(long_cnt[2]), 32'd1);
        check("k2_press_total", 32'(press_cnt[2]), 32'd1);

        // Key 2: one-tick high glitch while held.
        run_ticks(1);
        i_sw = 4'b1111;
        run_ticks(1);
        check("k2_glitch_level", 32'(o_level), 32'h4);
        i_sw = 4'b1011;
        run_ticks(1);
        check("k2_glitch_evt_a", 32'(o_evt), 32'h0);
        run_ticks(1);
        check("k2_glitch_evt_b", 32'(o_evt), 32'h0);
        run_ticks(1);
        check("k2_glitch_rpt", 32'(o_evt), 32'h4);
        i_sw = 4'b1111;
        run_ticks(2);
        check("k2_rel_early", 32'(o_release), 32'h0);
        check("k2_rel_level", 32'(o_level), 32'h4);
        run_ticks(1);
        check("k2_release", 32'(o_release), 32'h4);
        check("k2_rel_level_drop", 32'(o_level), 32'h0);
        one_clk();
        check("k2_release_total", 32'(release_cnt[2]), 32'd1);
        check("k2_evt_final", 32'(evt_cnt[2]), 32'd8);

        // All four keys pressed on the same clk.
        i_sw = 4'b0000;
        run_ticks(2);
        check("all_press_early", 32'(o_press), 32'h0);
        run_ticks(1);
        check("all_press", 32'(o_press), 32'hF);
        check("all_evt", 32'(o_evt), 32'hF);
        check("all_level", 32'(o_level), 32'hF);
        i_sw = 4'b1111;
        run_ticks(3);
        check("all_release", 32'(o_release), 32'hF);
        check("all_level_drop", 32'(o_level), 32'h0);
        one_clk();

        // Key 3: reset during HELD with the key still down.
        i_sw = 4'b0111;
        run_ticks(3);
        check("k3_press", 32'(o_press), 32'h8);
        run_ticks(10);
        check("k3_long", 32'(o_long), 32'h8);
        run_ticks(2);
        check("k3_held_level", 32'(o_level), 32'h8);
        rst_n = 1'b0;
        #1;
        check("k3_reset_level", 32'(o_level), 32'h0);
        check("k3_reset_pulses", 32'({o_press, o_release, o_long, o_evt}), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_ticks(2);
        check("k3_repress_early", 32'(o_press), 32'h0);
        check("k3_repress_level_early", 32'(o_level), 32'h0);
        run_ticks(1);
        check("k3_repress", 32'(o_press), 32'h8);
        check("k3_repress_level", 32'(o_level), 32'h8);
        i_sw = 4'b1111;
        run_ticks(3);
        check("k3_release", 32'(o_release), 32'h8);
        one_clk();

        check("pulse_width_overlap", 32'(pulse_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
